// File: rtl/l1b_read_request_queue.sv
// Per-source read-request queue feeding the L1 buffer read-address selector.
// Latency: a trigger captured at edge k can issue at edge k+1, so the pulse is high one cycle later.
// Backpressure: none upstream; a push into a full queue is dropped, recorded in sticky flags and DropCnt.

module l1b_rrq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             drop
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when it pops on the same edge.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module l1b_read_request_queue #(
    parameter int ADDR_WIDTH = 8,
    parameter int R3_DEPTH   = 4,
    parameter int L1_DEPTH   = 4,
    parameter int ISSUE_GAP  = 4
) (
    input  logic                  CLK,
    input  logic                  RSTB,
    input  logic                  R3_Trig,
    input  logic                  L1_Trig,
    input  logic [ADDR_WIDTH-1:0] WrAddr,
    input  logic [ADDR_WIDTH-1:0] Latency,
    input  logic                  ClrOvf,
    output logic                  AI,
    output logic                  BI,
    output logic [ADDR_WIDTH-1:0] AddressIn1,
    output logic [ADDR_WIDTH-1:0] AddressIn2,
    output logic                  R3_Ovf,
    output logic                  L1_Ovf,
    output logic [7:0]            DropCnt,
    output logic                  Busy
);
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    typedef enum logic {IDLE, GAP} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [GW-1:0]         gap_q;
    logic [GW-1:0]         gap_d;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic [ADDR_WIDTH-1:0] r3_dat;
    logic [ADDR_WIDTH-1:0] l1_dat;
    logic                  r3_empty;
    logic                  l1_empty;
    logic                  r3_drop;
    logic                  l1_drop;
    logic                  any_pending;
    logic                  issue_slot;
    logic                  issue_r3;
    logic                  issue_l1;
    logic [1:0]            drop_inc;
    logic [8:0]            drop_sum;

    assign trig_addr = WrAddr - Latency;

    l1b_rrq_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(R3_DEPTH)) u_r3_fifo (
        .clk      (CLK),
        .rst_n    (RSTB),
        .push     (R3_Trig),
        .push_dat (trig_addr),
        .pop      (issue_r3),
        .pop_dat  (r3_dat),
        .empty    (r3_empty),
        .drop     (r3_drop)
    );

    l1b_rrq_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(L1_DEPTH)) u_l1_fifo (
        .clk      (CLK),
        .rst_n    (RSTB),
        .push     (L1_Trig),
        .push_dat (trig_addr),
        .pop      (issue_l1),
        .pop_dat  (l1_dat),
        .empty    (l1_empty),
        .drop     (l1_drop)
    );

    assign any_pending = !r3_empty || !l1_empty;
    assign issue_slot  = (state_q == IDLE) || (gap_q == '0);

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_ONE;
                end else if (any_pending) begin
                    gap_d = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase
    end

    // R3 has strict priority; L1 only issues when the R3 queue is empty.
    always_comb begin
        issue_r3 = 1'b0;
        issue_l1 = 1'b0;
        if (issue_slot) begin
            issue_r3 = !r3_empty;
            issue_l1 = r3_empty && !l1_empty;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            AI         <= 1'b0;
            BI         <= 1'b0;
            AddressIn1 <= '0;
            AddressIn2 <= '0;
        end else begin
            AI <= issue_r3;
            BI <= issue_l1;
            if (issue_r3) begin
                AddressIn1 <= r3_dat;
            end
            if (issue_l1) begin
                AddressIn2 <= l1_dat;
            end
        end
    end

    assign drop_inc = {1'b0, r3_drop} + {1'b0, l1_drop};
    assign drop_sum = {1'b0, DropCnt} + {7'b0, drop_inc};

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            R3_Ovf  <= 1'b0;
            L1_Ovf  <= 1'b0;
            DropCnt <= '0;
        end else if (ClrOvf) begin
            R3_Ovf  <= 1'b0;
            L1_Ovf  <= 1'b0;
            DropCnt <= '0;
        end else begin
            if (r3_drop) begin
                R3_Ovf <= 1'b1;
            end
            if (l1_drop) begin
                L1_Ovf <= 1'b1;
            end
            DropCnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // GAP covers the whole strobe window of the last issue, so Busy spans it too.
    assign Busy = (state_q == GAP) || any_pending;
endmodule

// File: tb/tb_l1b_read_request_queue.sv
// Bench for l1b_read_request_queue: directed scenarios plus random traffic
// compared each cycle against a queue-level behavioural model.

module tb_l1b_read_request_queue;
    localparam int AW  = 8;
    localparam int R3D = 4;
    localparam int L1D = 4;
    localparam int GAP = 4;

    logic          CLK = 1'b0;
    logic          RSTB;
    logic          R3_Trig;
    logic          L1_Trig;
    logic [AW-1:0] WrAddr;
    logic [AW-1:0] Latency;
    logic          ClrOvf;
    logic          AI;
    logic          BI;
    logic [AW-1:0] AddressIn1;
    logic [AW-1:0] AddressIn2;
    logic          R3_Ovf;
    logic          L1_Ovf;
    logic [7:0]    DropCnt;
    logic          Busy;

    always #5 CLK = ~CLK;

    l1b_read_request_queue #(
        .ADDR_WIDTH (AW),
        .R3_DEPTH   (R3D),
        .L1_DEPTH   (L1D),
        .ISSUE_GAP  (GAP)
    ) dut (
        .CLK        (CLK),
        .RSTB       (RSTB),
        .R3_Trig    (R3_Trig),
        .L1_Trig    (L1_Trig),
        .WrAddr     (WrAddr),
        .Latency    (Latency),
        .ClrOvf     (ClrOvf),
        .AI         (AI),
        .BI         (BI),
        .AddressIn1 (AddressIn1),
        .AddressIn2 (AddressIn2),
        .R3_Ovf     (R3_Ovf),
        .L1_Ovf     (L1_Ovf),
        .DropCnt    (DropCnt),
        .Busy       (Busy)
    );

    // Reference model: request queues plus the edge index of the last issue.
    logic [AW-1:0] mq_r3[$];
    logic [AW-1:0] mq_l1[$];
    int            last_iss;
    int            cyc;
    logic          m_ai, m_bi, m_r3ovf, m_l1ovf, m_busy;
    logic [AW-1:0] m_a1, m_a2;
    int            m_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int bi_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mq_r3.delete();
        mq_l1.delete();
        last_iss = -1000;
        m_ai = 0; m_bi = 0; m_a1 = '0; m_a2 = '0;
        m_r3ovf = 0; m_l1ovf = 0; m_cnt = 0; m_busy = 0;
    endtask

    task automatic model_edge();
        logic can;
        logic [AW-1:0] addr;
        int ndrop;
        can   = (cyc - last_iss) >= GAP;
        m_ai  = can && (mq_r3.size() > 0);
        m_bi  = can && !m_ai && (mq_l1.size() > 0);
        if (m_ai) begin m_a1 = mq_r3.pop_front(); last_iss = cyc; end
        if (m_bi) begin m_a2 = mq_l1.pop_front(); last_iss = cyc; end
        addr  = WrAddr - Latency;
        ndrop = 0;
        if (R3_Trig) begin
            if (mq_r3.size() < R3D) mq_r3.push_back(addr);
            else begin ndrop++; if (!ClrOvf) m_r3ovf = 1; end
        end
        if (L1_Trig) begin
            if (mq_l1.size() < L1D) mq_l1.push_back(addr);
            else begin ndrop++; if (!ClrOvf) m_l1ovf = 1; end
        end
        if (ClrOvf) begin
            m_r3ovf = 0; m_l1ovf = 0; m_cnt = 0;
        end else begin
            m_cnt = (m_cnt + ndrop > 255) ? 255 : m_cnt + ndrop;
        end
        m_busy = (mq_r3.size() + mq_l1.size() > 0) || ((cyc - last_iss) < GAP);
        cyc++;
    endtask

    task automatic check_outputs();
        chk("AI", AI, m_ai);
        chk("BI", BI, m_bi);
        chk("AddressIn1", AddressIn1, m_a1);
        chk("AddressIn2", AddressIn2, m_a2);
        chk("R3_Ovf", R3_Ovf, m_r3ovf);
        chk("L1_Ovf", L1_Ovf, m_l1ovf);
        chk("DropCnt", DropCnt, m_cnt);
        chk("Busy", Busy, m_busy);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
        if (BI) bi_seen++;
    endtask

    task automatic idle(input int n);
        R3_Trig = 0; L1_Trig = 0; ClrOvf = 0;
        repeat (n) step();
    endtask

    // Called #1 after an edge; reset lands mid-cycle and must act at once.
    task automatic do_reset();
        #2;
        RSTB = 0;
        R3_Trig = 0; L1_Trig = 0; ClrOvf = 0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge CLK);
        #1;
        RSTB = 1;
    endtask

    initial begin
        RSTB = 0; R3_Trig = 0; L1_Trig = 0; ClrOvf = 0;
        WrAddr = '0; Latency = '0;
        cyc = 0; bi_seen = 0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge CLK);
        #1;
        RSTB = 1;

        // Basic L1 request
        WrAddr = 8'h10; Latency = 8'h05; L1_Trig = 1;
        step();
        L1_Trig = 0;
        step();
        chk("basic_bi", BI, 1);
        chk("basic_a2", AddressIn2, 8'h0B);
        idle(8);

        // Address wrap on R3
        WrAddr = 8'h02; Latency = 8'h05; R3_Trig = 1;
        step();
        R3_Trig = 0;
        step();
        chk("wrap_ai", AI, 1);
        chk("wrap_a1", AddressIn1, 8'hFD);
        idle(8);

        // Simultaneous triggers: R3 first, L1 four cycles later
        WrAddr = 8'h40; Latency = 8'h10; R3_Trig = 1; L1_Trig = 1;
        step();
        R3_Trig = 0; L1_Trig = 0;
        step();
        chk("sim_ai", AI, 1);
        chk("sim_a1", AddressIn1, 8'h30);
        repeat (4) step();
        chk("sim_bi", BI, 1);
        chk("sim_a2", AddressIn2, 8'h30);
        repeat (3) step();
        chk("sim_busy_hold", Busy, 1);
        step();
        chk("sim_busy_fall", Busy, 0);
        idle(4);

        // L1 overflow: 8 back-to-back triggers into a 4-deep queue
        bi_seen = 0;
        Latency = 8'h00;
        for (int i = 0; i < 8; i++) begin
            L1_Trig = 1;
            WrAddr  = 8'h20 + 8'(i);
            step();
        end
        L1_Trig = 0;
        chk("ovf_flag", L1_Ovf, 1);
        chk("ovf_cnt", DropCnt, 2);
        idle(30);
        chk("ovf_bi_count", bi_seen, 6);
        ClrOvf = 1;
        step();
        ClrOvf = 0;
        chk("clr_flag", L1_Ovf, 0);
        chk("clr_cnt", DropCnt, 0);
        idle(4);

        // Reset during GAP discards pending requests
        Latency = 8'h03;
        for (int i = 0; i < 3; i++) begin
            L1_Trig = 1;
            WrAddr  = 8'h50 + 8'(i);
            step();
        end
        L1_Trig = 0;
        repeat (2) step();
        do_reset();
        bi_seen = 0;
        idle(12);
        chk("post_reset_bi", bi_seen, 0);

        // R3 starvation of a single L1 request
        for (int i = 0; i < 12; i++) begin
            R3_Trig = 1;
            L1_Trig = (i == 0);
            WrAddr  = 8'h80 + 8'(i);
            step();
        end
        idle(40);

        // Heavy traffic without clears to drive DropCnt into saturation
        for (int i = 0; i < 400; i++) begin
            R3_Trig = ($urandom_range(0, 99) < 90);
            L1_Trig = ($urandom_range(0, 99) < 90);
            WrAddr  = AW'($urandom);
            step();
        end
        chk("sat_cnt", DropCnt, 255);
        idle(40);

        // Mixed random traffic with clears, latency changes and resets
        for (int i = 0; i < 2000; i++) begin
            int p;
            p = (i / 250) % 2 == 0 ? 15 : 45;
            R3_Trig = ($urandom_range(0, 99) < p);
            L1_Trig = ($urandom_range(0, 99) < p);
            WrAddr  = AW'($urandom);
            ClrOvf  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) Latency = AW'($urandom);
            if ($urandom_range(0, 399) == 0) do_reset();
            else step();
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
